// File: rtl/digit_to_seg.sv
`default_nettype none
// ============================================================================
// digit_to_seg : time-multiplexed hex-digit driver for a common-anode
//                7-segment display (active-low an/seg/dp, registered outputs)
// Revision     : 1.0
// ============================================================================
module digit_to_seg #(
  parameter int                DIGITS      = 4,
  parameter int                REFRESH_DIV = 100000,
  parameter logic [DIGITS-1:0] DP_MASK     = '0
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [3:0]        in1,
  input  logic [3:0]        in2,
  input  logic [3:0]        in3,
  input  logic [3:0]        in4,
  input  logic [3:0]        in5,
  input  logic [3:0]        in6,
  input  logic [3:0]        in7,
  input  logic [3:0]        in8,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int                CNT_W    = $clog2(REFRESH_DIV);
  localparam int                IDX_W    = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [2:0]        sel;
  logic [3:0]        digit;

  assign sel = 3'(idx_q);

  // Positions above DIGITS-1 are unreachable, so in5..in8 drop out for DIGITS=4
  always_comb begin
    digit = in1;
    case (sel)
      3'd0:    digit = in1;
      3'd1:    digit = in2;
      3'd2:    digit = in3;
      3'd3:    digit = in4;
      3'd4:    digit = in5;
      3'd5:    digit = in6;
      3'd6:    digit = in7;
      default: digit = in8;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    an_d = ~(AN_ONE << idx_q);
    dp_d = ~DP_MASK[idx_q];

    // Active-low gfedcba
    seg_d = 7'b1111111;
    case (digit)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_to_seg.sv
`default_nettype none
// ============================================================================
// tb_digit_to_seg : directed bench for digit_to_seg (4-digit and 8-digit builds)
// Revision        : 1.0
// ============================================================================
module tb_digit_to_seg;

  logic       mclk = 1'b0;
  logic       reset;
  logic [3:0] in1, in2, in3, in4, in5, in6, in7, in8;
  logic [3:0] an4;
  logic [6:0] seg4;
  logic       dp4;
  logic [7:0] an8;
  logic [6:0] seg8;
  logic       dp8;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 mclk = ~mclk;

  digit_to_seg #(.DIGITS(4), .REFRESH_DIV(4), .DP_MASK(4'b0100)) dut4 (
    .mclk(mclk), .reset(reset),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8),
    .an(an4), .seg(seg4), .dp(dp4)
  );

  digit_to_seg #(.DIGITS(8), .REFRESH_DIV(2), .DP_MASK(8'h00)) dut8 (
    .mclk(mclk), .reset(reset),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8),
    .an(an8), .seg(seg8), .dp(dp8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         e;
    int         d4, d8;
    logic [3:0] ea4;
    logic [7:0] ea8;

    reset = 1'b1;
    in1 = 4'd1; in2 = 4'd2; in3 = 4'd3; in4 = 4'd4;
    in5 = 4'd5; in6 = 4'd6; in7 = 4'd7; in8 = 4'd8;

    // Reset hold
    repeat (5) begin
      step();
      check("rst_an4",  an4,  4'hF);
      check("rst_seg4", seg4, 7'h7F);
      check("rst_dp4",  dp4,  1'b1);
      check("rst_an8",  an8,  8'hFF);
    end

    // Scan order: dut4 slot = 4 edges, dut8 slot = 2 edges
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      d4  = ((k - 1) / 4) % 4;
      d8  = ((k - 1) / 2) % 8;
      ea4 = ~(4'b0001 << d4);
      ea8 = ~(8'b00000001 << d8);
      check("scan_an4",  an4,  ea4);
      check("scan_seg4", seg4, seg_tbl[d4 + 1]);
      check("scan_dp4",  dp4,  (d4 == 2) ? 1'b0 : 1'b1);
      check("scan_an8",  an8,  ea8);
      check("scan_seg8", seg8, seg_tbl[d8 + 1]);
      check("scan_dp8",  dp8,  1'b1);
    end

    step();
    check("wrap_an4",  an4,  4'b1110);
    check("wrap_seg4", seg4, 7'b1111001);
    check("wrap_an8",  an8,  8'b11111110);
    e = 17;

    // Full decode: change in1 while the next edge still shows digit 0
    for (int v = 0; v < 16; v++) begin
      while (((e / 4) % 4) != 0) begin
        step();
        e++;
      end
      in1 = 4'(v);
      step();
      e++;
      check("dec_an4",  an4,  4'b1110);
      check("dec_seg4", seg4, seg_tbl[v]);
    end

    // Mid-scan reset while digit 2 is lit
    in1 = 4'd1;
    while (((e / 4) % 4) != 2) begin
      step();
      e++;
    end
    step();
    check("mid_an4_pre", an4, 4'b1011);
    check("mid_dp4_pre", dp4, 1'b0);
    reset = 1'b1;
    step();
    check("mid_an4_rst",  an4,  4'hF);
    check("mid_seg4_rst", seg4, 7'h7F);
    check("mid_dp4_rst",  dp4,  1'b1);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check("mid_an4_d0",  an4,  4'b1110);
      check("mid_seg4_d0", seg4, 7'b1111001);
    end
    step();
    check("mid_an4_d1",  an4,  4'b1101);
    check("mid_seg4_d1", seg4, 7'b0100100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
